// File: rtl/sp_ram_pkg.sv
// Shared types and the byte-enable merge helper for the sp_ram_bw storage block.
package sp_ram_pkg;

  localparam int MAX_DATA_W = 512;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } rdw_mode_e;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Operates on the widest supported word; callers extend and truncate.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   mask
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sp_ram_bw_if.sv
// Access bus for sp_ram_bw: request side driven by the master, status/read side by the RAM.
interface sp_ram_bw_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic                  clear_req;
  logic                  rd_en;
  logic                  wr_en;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  ready;
  logic                  addr_err;

  modport master (
    output clear_req, rd_en, wr_en, addr, wr_data, byte_en,
    input  rd_data, rd_valid, ready, addr_err
  );

  modport slave (
    input  clear_req, rd_en, wr_en, addr, wr_data, byte_en,
    output rd_data, rd_valid, ready, addr_err
  );
endinterface

// File: rtl/sp_ram_clear_seq.sv
// Clear sweep sequencer: walks every word once after reset or on request, then reports ready.
module sp_ram_clear_seq
  import sp_ram_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [0:0]      S_CLEAR = CLEAR;
  localparam logic [0:0]      S_IDLE  = IDLE;
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);

  logic [0:0]      state;
  // One extra bit so the count cannot wrap when DEPTH is a power of two.
  logic [ADDR_W:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (cnt == LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + (ADDR_W+1)'(1);
          end
        end
        default: begin
          if (clear_req) begin
            state <= S_CLEAR;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign ready    = (state == S_IDLE);
  assign clr_we   = (state == S_CLEAR);
  assign clr_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/sp_ram_bw.sv
// Single-port RAM with byte enables, selectable read-during-write behaviour and optional output register.
module sp_ram_bw
  import sp_ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  sp_ram_bw_if.slave  bus
);

  localparam rdw_mode_e       MODE    = rdw_mode_e'(RDW_MODE);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              in_range;
  logic              accept;
  logic              do_wr;
  logic              do_rd;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] new_word;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] rd_data_p0;
  logic              vld_p0;
  logic              err_p0;

  sp_ram_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clear_req (bus.clear_req),
    .ready     (ready),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign in_range = ({1'b0, bus.addr} < DEPTH_C);
  assign accept   = ready & (bus.rd_en | bus.wr_en);
  assign do_wr    = ready & bus.wr_en & in_range;
  // NO_CHANGE suppresses the read half of a combined access; the write still lands.
  assign do_rd    = ready & bus.rd_en & ~(bus.wr_en && (MODE == NO_CHANGE));

  assign old_word = in_range ? mem[bus.addr] : '0;
  assign new_word = DATA_W'(byte_merge(MAX_DATA_W'(old_word),
                                       MAX_DATA_W'(bus.wr_data),
                                       MAX_BE_W'(bus.byte_en)));
  assign rd_word  = ((MODE == WRITE_FIRST) && bus.wr_en && in_range) ? new_word : old_word;

  // The sweep owns the write port while ready is low, so the two sources never collide.
  always_ff @(posedge clk) begin
    if (clr_we)     mem[clr_addr] <= CLEAR_VAL;
    else if (do_wr) mem[bus.addr] <= new_word;
  end

  // Stage p0: array read register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_p0 <= '0;
      vld_p0     <= 1'b0;
      err_p0     <= 1'b0;
    end else begin
      if (do_rd) rd_data_p0 <= rd_word;
      vld_p0 <= do_rd;
      err_p0 <= accept & ~in_range;
    end
  end

  // Stage p1: optional output register
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] rd_data_p1;
      logic              vld_p1;
      logic              err_p1;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
          err_p1     <= 1'b0;
        end else begin
          if (vld_p0) rd_data_p1 <= rd_data_p0;
          vld_p1 <= vld_p0;
          err_p1 <= err_p0;
        end
      end

      assign bus.rd_data  = rd_data_p1;
      assign bus.rd_valid = vld_p1;
      assign bus.addr_err = err_p1;
    end else begin : g_no_reg
      assign bus.rd_data  = rd_data_p0;
      assign bus.rd_valid = vld_p0;
      assign bus.addr_err = err_p0;
    end
  endgenerate

  assign bus.ready = ready;

endmodule

// File: tb/tb_sp_ram_bw.sv
// Directed bench for sp_ram_bw: four instances covering the three read-during-write modes and the output register.
module tb_sp_ram_bw;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_req;
  logic        rd_en;
  logic        wr_en;
  logic [3:0]  addr;
  logic [31:0] wr_data;
  logic [3:0]  byte_en;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sp_ram_bw_if #(.DATA_W(32), .ADDR_W(4)) b0 ();
  sp_ram_bw_if #(.DATA_W(32), .ADDR_W(4)) b1 ();
  sp_ram_bw_if #(.DATA_W(32), .ADDR_W(4)) b2 ();
  sp_ram_bw_if #(.DATA_W(32), .ADDR_W(4)) b3 ();

  assign b0.clear_req = clear_req;
  assign b0.rd_en     = rd_en;
  assign b0.wr_en     = wr_en;
  assign b0.addr      = addr;
  assign b0.wr_data   = wr_data;
  assign b0.byte_en   = byte_en;
  assign b1.clear_req = clear_req;
  assign b1.rd_en     = rd_en;
  assign b1.wr_en     = wr_en;
  assign b1.addr      = addr;
  assign b1.wr_data   = wr_data;
  assign b1.byte_en   = byte_en;
  assign b2.clear_req = clear_req;
  assign b2.rd_en     = rd_en;
  assign b2.wr_en     = wr_en;
  assign b2.addr      = addr;
  assign b2.wr_data   = wr_data;
  assign b2.byte_en   = byte_en;
  assign b3.clear_req = clear_req;
  assign b3.rd_en     = rd_en;
  assign b3.wr_en     = wr_en;
  assign b3.addr      = addr;
  assign b3.wr_data   = wr_data;
  assign b3.byte_en   = byte_en;

  sp_ram_bw #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  sp_ram_bw #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  sp_ram_bw #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .RDW_MODE(2), .OUT_REG(0)) u2 (.clk(clk), .rst(rst), .bus(b2));
  sp_ram_bw #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(1)) u3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; addr = a; wr_data = d; byte_en = be;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en = 1'b1; addr = a;
    step();
    rd_en = 1'b0;
  endtask

  // Counts edges until ready rises (bounded); also reports any rd_valid seen meanwhile.
  task automatic wait_ready(output int n, output logic any_vld);
    n = 0;
    any_vld = 1'b0;
    do begin
      step();
      n++;
      any_vld = any_vld | b0.rd_valid;
    end while (!b0.ready && n < 40);
  endtask

  logic [31:0] exp_mem [12];
  int          n;
  logic        any_vld;

  initial begin
    rst = 1'b1; clear_req = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    addr = '0; wr_data = '0; byte_en = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {b0.ready, b0.rd_valid, b0.addr_err, b0.rd_data}, 64'h0);
    check("reset_state_outreg", {b3.ready, b3.rd_valid, b3.addr_err, b3.rd_data}, 64'h0);

    rst = 1'b0;
    wait_ready(n, any_vld);
    check("sweep_len_after_reset", n, 12);

    for (int a = 0; a < 12; a++) begin
      rd_en = 1'b1; addr = 4'(a);
      step();
      check($sformatf("init_read_%0d", a), {b0.rd_valid, b0.rd_data}, {1'b1, 32'h0});
    end
    rd_en = 1'b0;
    step();
    check("rd_valid_drops", b0.rd_valid, 1'b0);

    wr(4'd3, 32'hAABBCCDD, 4'hF);
    wr(4'd3, 32'h11223344, 4'h5);
    rd(4'd3);
    check("byte_merge", {b0.rd_valid, b0.rd_data}, {1'b1, 32'hAA22CC44});
    wr(4'd3, 32'h00000000, 4'h0);
    rd(4'd3);
    check("zero_mask_write", {b0.rd_valid, b0.rd_data}, {1'b1, 32'hAA22CC44});

    rd_en = 1'b1; wr_en = 1'b1; addr = 4'd5; wr_data = 32'hDEADBEEF; byte_en = 4'hF;
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    check("rdw_read_first", {b0.rd_valid, b0.rd_data}, {1'b1, 32'h00000000});
    check("rdw_write_first", {b1.rd_valid, b1.rd_data}, {1'b1, 32'hDEADBEEF});
    check("rdw_no_change", {b2.rd_valid, b2.rd_data}, {1'b0, 32'hAA22CC44});
    rd(4'd5);
    check("rdw_after_m0", {b0.rd_valid, b0.rd_data}, {1'b1, 32'hDEADBEEF});
    check("rdw_after_m1", {b1.rd_valid, b1.rd_data}, {1'b1, 32'hDEADBEEF});
    check("rdw_after_m2", {b2.rd_valid, b2.rd_data}, {1'b1, 32'hDEADBEEF});

    wr(4'd1, 32'h01010101, 4'hF);
    wr(4'd2, 32'h02020202, 4'hF);
    step();
    rd_en = 1'b1; addr = 4'd1;
    step();
    check("outreg_lat_c1", b3.rd_valid, 1'b0);
    addr = 4'd2;
    step();
    check("outreg_c2", {b3.rd_valid, b3.rd_data}, {1'b1, 32'h01010101});
    check("noreg_c2", {b0.rd_valid, b0.rd_data}, {1'b1, 32'h02020202});
    addr = 4'd3;
    step();
    rd_en = 1'b0;
    check("outreg_c3", {b3.rd_valid, b3.rd_data}, {1'b1, 32'h02020202});
    step();
    check("outreg_c4", {b3.rd_valid, b3.rd_data}, {1'b1, 32'hAA22CC44});
    step();
    check("outreg_hold", {b3.rd_valid, b3.rd_data}, {1'b0, 32'hAA22CC44});

    wr(4'd13, 32'h12345678, 4'hF);
    check("oor_write_err", {b0.addr_err, b0.rd_valid}, 2'b10);
    step();
    check("oor_err_pulse", b0.addr_err, 1'b0);
    rd(4'd12);
    check("oor_read", {b0.addr_err, b0.rd_valid, b0.rd_data}, {2'b11, 32'h0});
    check("oor_outreg_early", b3.addr_err, 1'b0);
    step();
    check("oor_outreg", {b3.addr_err, b3.rd_valid, b3.rd_data}, {2'b11, 32'h0});
    check("oor_err_single", b0.addr_err, 1'b0);

    for (int a = 0; a < 12; a++) exp_mem[a] = 32'h0;
    exp_mem[1] = 32'h01010101;
    exp_mem[2] = 32'h02020202;
    exp_mem[3] = 32'hAA22CC44;
    exp_mem[5] = 32'hDEADBEEF;
    for (int a = 0; a < 12; a++) begin
      rd(4'(a));
      check($sformatf("post_oor_%0d", a), {b0.rd_valid, b0.rd_data}, {1'b1, exp_mem[a]});
    end

    for (int a = 0; a < 12; a++) wr(4'(a), 32'hFFFFFFFF, 4'hF);
    clear_req = 1'b1; rd_en = 1'b1; addr = 4'd4;
    step();
    clear_req = 1'b0; addr = 4'd7;
    check("clear_same_cycle_read", {b0.ready, b0.rd_valid, b0.rd_data}, {2'b01, 32'hFFFFFFFF});
    wait_ready(n, any_vld);
    rd_en = 1'b0;
    check("sweep_len_clear", n, 12);
    check("no_valid_in_sweep", any_vld, 1'b0);
    for (int a = 0; a < 12; a++) begin
      rd(4'(a));
      check($sformatf("cleared_%0d", a), {b0.rd_valid, b0.rd_data}, {1'b1, 32'h0});
    end

    wr(4'd2, 32'h5A5A5A5A, 4'hF);
    rd(4'd2);
    check("pre_abort_read", b0.rd_data, 32'h5A5A5A5A);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("async_reset_mid_sweep", {b0.ready, b0.rd_valid, b0.addr_err, b0.rd_data}, 64'h0);
    step();
    rst = 1'b0;
    wait_ready(n, any_vld);
    check("sweep_len_restart", n, 12);
    rd(4'd2);
    check("restart_cleared", {b0.rd_valid, b0.rd_data}, {1'b1, 32'h0});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
